bcd_serial_subtractor: RTL and testbench
========================================

// Module: bcd_serial_subtractor
// PURPOSE
//  Multi-digit packed-BCD subtractor, diff = a - b. Counterpart to the lab's BCD adder datapath.
//  Digit-serial: one BCD digit per clock, LSD first, with a start/done handshake.
//  Sits beside the BCD adder so decimal counters and calculators can also decrement or subtract.
// PARAMETERS
//  DIGITS  4  number of BCD digits per operand (>=1); operand width = 4*DIGITS
// PORTS
//  clk         in   1         clock; all state updates on rising edge
//  rst         in   1         synchronous, active-high reset
//  start       in   1         request; sampled only in IDLE
//  a           in   4*DIGITS  minuend, packed BCD, digit 0 = bits [3:0]
//  b           in   4*DIGITS  subtrahend, packed BCD
//  diff        out  4*DIGITS  result, packed BCD (registered)
//  borrow_out  out  1         1 when a < b; diff is then the ten's complement of (b - a)
//  invalid     out  1         1 when any captured digit of a or b is > 9
//  busy        out  1         1 whenever state != IDLE
//  done        out  1         one-cycle pulse: diff, borrow_out and invalid are valid
// BEHAVIOUR
//  - Clock/reset: one clock (clk); reset is synchronous and active-high (rst).
//  - Reset: state=IDLE. diff=0, borrow_out=0, invalid=0, busy=0, done=0, internal borrow=0.
//  - rst overrides everything, including mid-RUN; the operation is aborted and its result discarded.
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE, start=1:
//    - a and b are copied into shift registers; digit counter=0; borrow=0.
//    - Every digit is checked; if any digit > 9, go to DONE with diff=0, borrow_out=0, invalid=1.
//    - Otherwise clear invalid and go to RUN.
//  - IDLE, start=0: hold. diff, borrow_out and invalid keep their last values.
//  - RUN, one cycle per digit (i = 0..DIGITS-1):
//    - t = a_i - b_i - borrow, computed at 5-bit signed width.
//    - If t < 0: digit = t + 10 and borrow = 1; else digit = t and borrow = 0.
//    - The digit is shifted into diff from the MSD end; the operand registers shift right by 4.
//    - After digit DIGITS-1: borrow_out = final borrow, then go to DONE.
//  - DONE: done=1 for exactly this one cycle, then IDLE. diff stays stable until the next accepted start.
//  - Latency: start accepted in cycle 0 -> done in cycle DIGITS+1. Invalid path: done in cycle 1.
//  - start in RUN or DONE is ignored (not queued). Minimum spacing between accepted starts is DIGITS+2 cycles.
//  - During RUN, diff holds partially shifted data and is only meaningful when done=1.
//  - Changes to a and b after capture have no effect on the operation in flight.
//  - Wrap-around: a < b gives the modulo 10^DIGITS result, e.g. 0 - 1 = all 9s with borrow_out=1.
//  - A borrow ripples correctly through any run of zero digits.
// STRUCTURE
//  - Package bcd_pkg holds:
//    - localparam BCD_MAX = 4'd9 and BCD_BASE = 5'd10
//    - the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
//    - a function is_bcd_digit(4-bit) returning 1 when the digit is <= 9
//  - Sub-module bcd_digit_sub (combinational), one instance:
//    - inputs x[3:0], y[3:0], bin; outputs d[3:0], bout
//    - implements the single-digit rule given in BEHAVIOUR
//  - Top-level contents: FSM, digit counter ($clog2(DIGITS+1) bits), operand shift registers,
//    diff shift register, borrow flop, invalid check.
// TESTING (DIGITS=4, values in hex = packed BCD)
//  1. a=0042, b=0017, start pulse -> done exactly 5 cycles later; diff=0025, borrow_out=0, invalid=0.
//  2. a=1000, b=0001 -> diff=0999, borrow_out=0 (borrow ripples through zeros);
//     a=9999, b=9999 -> diff=0000, borrow_out=0.
//  3. a=0017, b=0042 -> diff=9975, borrow_out=1; a=0000, b=0001 -> diff=9999, borrow_out=1.
//  4. a=00A3, b=0001 -> done 1 cycle after start; invalid=1, diff=0000, borrow_out=0, busy=0 next cycle.
//  5. start re-pulsed during RUN and DONE, with a/b changed mid-RUN -> ignored;
//     the first result is unaffected and only one done pulse occurs.
//  6. rst asserted at cycle 2 of RUN -> next cycle busy=0, done=0, diff=0;
//     a fresh start afterwards gives a correct result.
//  - Bench compares every run against a behavioural decimal model over 1000 random valid operand pairs.

Source files
------------

// File: rtl/bcd_serial_subtractor_pkg.sv
// Shared constants, FSM encoding and digit-validity helper for the serial BCD subtractor.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [4:0] BCD_BASE = 5'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_bcd_digit(input logic [3:0] v);
        return (v <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_serial_subtractor_if.sv
// Start/done request bus carrying the packed-BCD operands and the result.
interface bcd_serial_subtractor_if #(
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned W = 4 * DIGITS;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         invalid;
    logic         busy;
    logic         done;

    modport master (
        output start, a, b,
        input  diff, borrow_out, invalid, busy, done
    );

    modport slave (
        input  start, a, b,
        output diff, borrow_out, invalid, busy, done
    );

endinterface

// File: rtl/bcd_serial_subtractor_digit_sub.sv
// One BCD digit of x - y - bin, with ten's-complement correction on underflow.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);

    logic signed [4:0] t;
    logic        [4:0] corrected;

    always_comb begin
        t         = $signed({1'b0, x}) - $signed({1'b0, y}) - $signed({4'b0000, bin});
        bout      = (t < 5'sd0);
        corrected = $unsigned(t) + BCD_BASE;
        d         = bout ? corrected[3:0] : t[3:0];
    end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor, diff = a - b, one digit per clock starting at the LSD.
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    bcd_serial_subtractor_if.slave bus
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = $clog2(DIGITS + 1);

    state_t         state, state_next;
    logic [W-1:0]   a_sr, a_sr_next;
    logic [W-1:0]   b_sr, b_sr_next;
    logic [W-1:0]   diff_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic           borrow, borrow_next;
    logic           borrow_out_next, invalid_next, done_next, busy_next;
    logic           operands_ok;
    logic [3:0]     dig;
    logic           dig_bout;

    bcd_digit_sub u_digit (
        .x    (a_sr[3:0]),
        .y    (b_sr[3:0]),
        .bin  (borrow),
        .d    (dig),
        .bout (dig_bout)
    );

    // Every digit of both live operands must be a legal BCD digit
    always_comb begin
        operands_ok = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (!is_bcd_digit(bus.a[i*4 +: 4]) || !is_bcd_digit(bus.b[i*4 +: 4])) begin
                operands_ok = 1'b0;
            end
        end
    end

    always_comb begin
        state_next      = state;
        a_sr_next       = a_sr;
        b_sr_next       = b_sr;
        cnt_next        = cnt;
        borrow_next     = borrow;
        diff_next       = bus.diff;
        borrow_out_next = bus.borrow_out;
        invalid_next    = bus.invalid;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    a_sr_next   = bus.a;
                    b_sr_next   = bus.b;
                    cnt_next    = '0;
                    borrow_next = 1'b0;
                    if (!operands_ok) begin
                        diff_next       = '0;
                        borrow_out_next = 1'b0;
                        invalid_next    = 1'b1;
                        state_next      = DONE;
                    end else begin
                        invalid_next = 1'b0;
                        state_next   = RUN;
                    end
                end
            end
            RUN: begin
                // Result digits enter at the MSD end so digit 0 lands in [3:0] after the last shift
                diff_next            = bus.diff >> 4;
                diff_next[W-1 -: 4]  = dig;
                a_sr_next            = a_sr >> 4;
                b_sr_next            = b_sr >> 4;
                borrow_next          = dig_bout;
                cnt_next             = cnt + CW'(1);
                if (cnt == CW'(DIGITS - 1)) begin
                    borrow_out_next = dig_bout;
                    state_next      = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        done_next = (state_next == DONE);
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            a_sr           <= '0;
            b_sr           <= '0;
            cnt            <= '0;
            borrow         <= 1'b0;
            bus.diff       <= '0;
            bus.borrow_out <= 1'b0;
            bus.invalid    <= 1'b0;
            bus.done       <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            state          <= state_next;
            a_sr           <= a_sr_next;
            b_sr           <= b_sr_next;
            cnt            <= cnt_next;
            borrow         <= borrow_next;
            bus.diff       <= diff_next;
            bus.borrow_out <= borrow_out_next;
            bus.invalid    <= invalid_next;
            bus.done       <= done_next;
            bus.busy       <= busy_next;
        end
    end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed and randomised checks of the 4-digit serial BCD subtractor against a decimal model.
module tb_bcd_serial_subtractor;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bcd_serial_subtractor_if #(.DIGITS(4)) bus ();

    bcd_serial_subtractor #(.DIGITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic int bcd2int(input logic [15:0] v);
        int r;
        r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int n);
        logic [15:0] r;
        int m;
        m = n;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    // Issues one start and waits (bounded) for done; returns cycle index of done
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                          output logic [15:0] d, output logic bo, output logic inv,
                          output logic bsy1, output int lat);
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bsy1 = bus.busy;
        lat  = 1;
        while (bus.done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        d   = bus.diff;
        bo  = bus.borrow_out;
        inv = bus.invalid;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.borrow_out, bus.invalid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: busy/done/bo/inv=%b required 0000",
                     {bus.busy, bus.done, bus.borrow_out, bus.invalid});
        end
        checks++;
        if (bus.diff !== 16'h0000) begin
            errors++;
            $display("FAIL reset_diff: got %h required 0000", bus.diff);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [15:0] d; logic bo, inv, bsy1; int lat;
        run_op(16'h0042, 16'h0017, d, bo, inv, bsy1, lat);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL basic_latency: got %0d required 5", lat); end
        checks++;
        if (d !== 16'h0025) begin errors++; $display("FAIL basic_diff: got %h required 0025", d); end
        checks++;
        if ({bo, inv} !== 2'b00) begin errors++; $display("FAIL basic_flags: bo/inv=%b required 00", {bo, inv}); end
        checks++;
        if (bsy1 !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b required 1", bsy1); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_idle: busy=%b required 0", bus.busy); end
    endtask

    task automatic test_ripple();
        logic [15:0] d; logic bo, inv, bsy1; int lat;
        run_op(16'h1000, 16'h0001, d, bo, inv, bsy1, lat);
        checks++;
        if (d !== 16'h0999 || bo !== 1'b0) begin
            errors++; $display("FAIL ripple_1000: got %h bo=%b required 0999 bo=0", d, bo);
        end
        run_op(16'h9999, 16'h9999, d, bo, inv, bsy1, lat);
        checks++;
        if (d !== 16'h0000 || bo !== 1'b0) begin
            errors++; $display("FAIL equal_9999: got %h bo=%b required 0000 bo=0", d, bo);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] d; logic bo, inv, bsy1; int lat;
        run_op(16'h0017, 16'h0042, d, bo, inv, bsy1, lat);
        checks++;
        if (d !== 16'h9975 || bo !== 1'b1) begin
            errors++; $display("FAIL wrap_17_42: got %h bo=%b required 9975 bo=1", d, bo);
        end
        run_op(16'h0000, 16'h0001, d, bo, inv, bsy1, lat);
        checks++;
        if (d !== 16'h9999 || bo !== 1'b1 || lat !== 5) begin
            errors++; $display("FAIL wrap_0_1: got %h bo=%b lat=%0d required 9999 bo=1 lat=5", d, bo, lat);
        end
    endtask

    task automatic test_invalid();
        logic [15:0] d; logic bo, inv, bsy1; int lat;
        run_op(16'h00A3, 16'h0001, d, bo, inv, bsy1, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL invalid_latency: got %0d required 1", lat); end
        checks++;
        if (inv !== 1'b1 || d !== 16'h0000 || bo !== 1'b0) begin
            errors++; $display("FAIL invalid_a: inv=%b diff=%h bo=%b required 1 0000 0", inv, d, bo);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL invalid_after: busy=%b done=%b required 0 0", bus.busy, bus.done);
        end
        run_op(16'h0001, 16'h00F0, d, bo, inv, bsy1, lat);
        checks++;
        if (inv !== 1'b1 || d !== 16'h0000 || lat !== 1) begin
            errors++; $display("FAIL invalid_b: inv=%b diff=%h lat=%0d required 1 0000 1", inv, d, lat);
        end
    endtask

    task automatic test_ignore_start();
        int ndone, done_cyc;
        logic [15:0] d;
        logic bo, inv;
        ndone = 0; done_cyc = -1; d = '0; bo = 1'bx; inv = 1'bx;
        bus.a = 16'h0042;
        bus.b = 16'h0017;
        bus.start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 10; c++) begin
            if (c == 2) begin bus.a = 16'h9999; bus.b = 16'h0000; end
            if (c == 6) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                ndone++; done_cyc = c; d = bus.diff; bo = bus.borrow_out; inv = bus.invalid;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (ndone !== 1 || done_cyc !== 5) begin
            errors++; $display("FAIL ignore_done_count: pulses=%0d at cycle %0d required 1 at 5", ndone, done_cyc);
        end
        checks++;
        if (d !== 16'h0025 || bo !== 1'b0 || inv !== 1'b0) begin
            errors++; $display("FAIL ignore_result: diff=%h bo=%b inv=%b required 0025 0 0", d, bo, inv);
        end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignore_idle: busy=%b required 0", bus.busy); end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] d; logic bo, inv, bsy1; int lat, ndone;
        bus.a = 16'h0042;
        bus.b = 16'h0017;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.diff !== 16'h0000) begin
            errors++; $display("FAIL midrun_reset: busy=%b done=%b diff=%h required 0 0 0000",
                               bus.busy, bus.done, bus.diff);
        end
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.done === 1'b1) ndone++;
            @(posedge clk); #1;
        end
        checks++;
        if (ndone !== 0) begin errors++; $display("FAIL midrun_no_done: pulses=%0d required 0", ndone); end
        run_op(16'h0100, 16'h0001, d, bo, inv, bsy1, lat);
        checks++;
        if (d !== 16'h0099 || bo !== 1'b0 || lat !== 5) begin
            errors++; $display("FAIL midrun_fresh: diff=%h bo=%b lat=%0d required 0099 0 5", d, bo, lat);
        end
    endtask

    task automatic test_random();
        logic [15:0] av, bv, d, exp_d;
        logic bo, inv, bsy1, exp_bo;
        int lat, n;
        for (int k = 0; k < 1000; k++) begin
            for (int i = 0; i < 4; i++) begin
                av[i*4 +: 4] = 4'($urandom_range(0, 9));
                bv[i*4 +: 4] = 4'($urandom_range(0, 9));
            end
            n = bcd2int(av) - bcd2int(bv);
            exp_bo = (n < 0);
            if (n < 0) n = n + 10000;
            exp_d = int2bcd(n);
            run_op(av, bv, d, bo, inv, bsy1, lat);
            checks++;
            if (d !== exp_d || bo !== exp_bo || inv !== 1'b0 || lat !== 5) begin
                errors++;
                $display("FAIL random %h-%h: diff=%h bo=%b inv=%b lat=%0d required %h %b 0 5",
                         av, bv, d, bo, inv, lat, exp_d, exp_bo);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_ripple();
        test_wrap();
        test_invalid();
        test_ignore_start();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
